// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads program memory and presents words to the decoder.
// Optional fetch-timeout watchdog is built when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit #(
  parameter int PC_WIDTH       = 8,
  parameter int INSTR_WIDTH    = 9,
  parameter int RESET_VECTOR   = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  output logic [PC_WIDTH-1:0]    o_PM_Addr,
  output logic                   o_PM_Req,
  input  logic [INSTR_WIDTH-1:0] i_PM_Data,
  input  logic                   i_PM_Valid,
  input  logic                   i_Stall,
  input  logic                   i_Branch_Take,
  input  logic [PC_WIDTH-1:0]    i_Branch_Target,
  output logic [INSTR_WIDTH-1:0] o_Instruction,
  output logic                   o_Instr_Valid,
  output logic [PC_WIDTH-1:0]    o_PC,
  output logic                   o_Fetch_Err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [PC_WIDTH-1:0]    r_opc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic                   r_req;
  logic                   w_timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = (r_state == FETCH) && !i_PM_Valid
                     && (r_cnt == CNT_LAST);

  // Counter only runs while a request is left unanswered.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != FETCH || i_Branch_Take
          || i_PM_Valid || w_timeout)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_timeout && !i_Branch_Take)
        r_err <= 1'b1;
    end
  end

  assign o_Fetch_Err = r_err;
`else
  assign w_timeout   = 1'b0;
  assign o_Fetch_Err = 1'b0;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= IDLE;
      r_pc    <= PC_RST;
      r_opc   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: begin
          if (i_Branch_Take) begin
            r_pc    <= i_Branch_Target;
            r_instr <= '0;
            r_valid <= 1'b0;
          end else if (i_PM_Valid) begin
            r_instr <= i_PM_Data;
            r_opc   <= r_pc;
            r_pc    <= r_pc + PC_ONE;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= HOLD;
          end else if (w_timeout) begin
            r_instr <= '0;
            r_opc   <= r_pc;
            r_pc    <= r_pc + PC_ONE;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (i_Branch_Take) begin
            r_pc    <= i_Branch_Target;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end else if (!i_Stall) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_PM_Addr     = r_pc;
  assign o_PM_Req      = r_req;
  assign o_Instruction = r_instr;
  assign o_Instr_Valid = r_valid;
  assign o_PC          = r_opc;

endmodule
